ps2_key_decoder: RTL

Receives the PS/2 keyboard serial stream, reassembles 11-bit frames and turns make/break scan-code sequences into held-level key flags `key_a`, `key_d` and `key_w`. The block sits between the keyboard pins and `move_ctr_fsm`. Each flag is 1 while its physical key is held. The block also exports every accepted scan byte as a one-cycle strobe for debug.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_key_decoder_if.sv | 23 ++
 rtl/ps2_key_decoder_rx_frame.sv | 131 +++++++++++++
 rtl/ps2_key_decoder.sv | 106 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder constants: scan codes and the receive-frame state type.
package ps2_pkg;

  localparam logic [7:0] SC_A   = 8'h1C;
  localparam logic [7:0] SC_D   = 8'h23;
  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Output bundle of the PS/2 key decoder: held key flags, debug byte strobe, error strobe, FSM state.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  // scan_valid and frame_err are single-cycle strobes with no ready: the consumer
  // must sample them in the cycle they are high; scan_code holds between strobes.
  logic         key_a;
  logic         key_d;
  logic         key_w;
  logic [7:0]   scan_code;
  logic         scan_valid;
  logic         frame_err;
  frame_state_e frame_state;

  modport master (
    output key_a, key_d, key_w, scan_code, scan_valid, frame_err, frame_state
  );

  modport slave (
    input key_a, key_d, key_w, scan_code, scan_valid, frame_err, frame_state
  );

endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM, timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         byte_ok,
  output logic [7:0]   rx_byte,
  output logic         err,
  output frame_state_e state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic         clk_s1_q, clk_s2_q, clk_prev_q;
  logic         dat_s1_q, dat_s2_q;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         fall;
  logic         par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_ok = ^{shreg_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign rx_byte = shreg_q;
  assign state   = state_q;

  // Synchronizers reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      tmo_q      <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = '0;
    byte_ok   = 1'b0;
    err       = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    if (state_q != IDLE) begin
      tmo_d = fall ? '0 : tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat_s2_q && par_ok) byte_ok = 1'b1;
          else                    err     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; a fall in the same cycle still wins.
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      tmo_d   = '0;
      err     = 1'b1;
      byte_ok = 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns make/break scan-code sequences into held A/D/W key flags.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 6_500_000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_key_decoder_if.master    key_if
);

  logic         rx_ok;
  logic         rx_err;
  logic [7:0]   rx_byte;
  frame_state_e rx_state;

  logic       key_a_q, key_a_d;
  logic       key_d_q, key_d_d;
  logic       key_w_q, key_w_d;
  logic [7:0] scan_code_q, scan_code_d;
  logic       scan_valid_q, scan_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .byte_ok (rx_ok),
    .rx_byte (rx_byte),
    .err     (rx_err),
    .state   (rx_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_a_q      <= 1'b0;
      key_d_q      <= 1'b0;
      key_w_q      <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      key_a_q      <= key_a_d;
      key_d_q      <= key_d_d;
      key_w_q      <= key_w_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
    end
  end

  always_comb begin
    key_a_d      = key_a_q;
    key_d_d      = key_d_q;
    key_w_d      = key_w_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = rx_err;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;

    if (rx_err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_ok) begin
      scan_code_d  = rx_byte;
      scan_valid_d = 1'b1;
      if (rx_byte == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        // Extended (E0-prefixed) codes never touch the movement keys.
        if (!ext_pend_q) begin
          if (rx_byte == SC_A) key_a_d = ~brk_pend_q;
          if (rx_byte == SC_D) key_d_d = ~brk_pend_q;
          if (rx_byte == SC_W) key_w_d = ~brk_pend_q;
        end
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  assign key_if.key_a       = key_a_q;
  assign key_if.key_d       = key_d_q;
  assign key_if.key_w       = key_w_q;
  assign key_if.scan_code   = scan_code_q;
  assign key_if.scan_valid  = scan_valid_q;
  assign key_if.frame_err   = frame_err_q;
  assign key_if.frame_state = rx_state;

endmodule
